// File: rtl/sim_frame_gen_pkg.sv
// Shared definitions for the simulated SYNC/SPCLK/DATA frame generator.
// Holds the pattern-mode encodings, the default rate constants used as
// parameter defaults, and the PRBS7 polynomial helper.
package sim_frame_gen_pkg;

    localparam int unsigned AD_MCLK_RATE  = 100_000_000;
    localparam int unsigned AD_SPCLK_RATE = 200_000;

    // x^7 + x^6 + 1: feedback taps on state bits 6 and 5
    localparam logic [6:0] PRBS7_TAPS = 7'h60;

    typedef enum logic [1:0] {
        SIM_MODE_SQUARE = 2'd0,
        SIM_MODE_HIGH   = 2'd1,
        SIM_MODE_CNT    = 2'd2,
        SIM_MODE_PRBS   = 2'd3
    } sim_mode_e;

    // One Fibonacci step of the PRBS7 register, shifting towards bit 6
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS7_TAPS)};
    endfunction

endpackage

// File: rtl/sim_frame_gen_if.sv
// Control and output bundle of sim_frame_gen.
//   en, mode        : generator enable and pattern select (into the generator)
//   out_spclk/sync  : simulated sample clock and frame sync
//   out_data        : NCHN simulated data lanes
//   sp_tick         : pulse at each sample boundary
//   frame_start     : pulse when sample_idx returns to 0
//   sample_idx      : current sample index (SW bits)
//   frame_idx       : current frame index (FW bits)
// master = generator side, slave = consumer side.
interface sim_frame_gen_if #(
    parameter int unsigned NCHN = 1,
    parameter int unsigned SW   = 9,
    parameter int unsigned FW   = 7
);
    logic            en;
    logic [1:0]      mode;
    logic            out_spclk;
    logic            out_sync;
    logic [NCHN-1:0] out_data;
    logic            sp_tick;
    logic            frame_start;
    logic [SW-1:0]   sample_idx;
    logic [FW-1:0]   frame_idx;

    modport master (
        input  en, mode,
        output out_spclk, out_sync, out_data, sp_tick, frame_start,
               sample_idx, frame_idx
    );

    modport slave (
        output en, mode,
        input  out_spclk, out_sync, out_data, sp_tick, frame_start,
               sample_idx, frame_idx
    );
endinterface

// File: rtl/sim_frame_gen_lane_pattern.sv
// sim_lane_pattern: combinational pattern bit for one simulated data lane.
// Ports:
//   clk, reset, load, tick : LFSR control (present only with SIM_FRAME_PRBS_EN)
//   sample_idx, frame_idx  : current position in the frame / superframe
//   mode                   : effective pattern mode
//   lane_bit_c             : unregistered lane bit, registered by the parent
// Macro SIM_FRAME_PRBS_EN builds the per-lane PRBS7 LFSR; without it mode 3
// falls back to the square pattern.
module sim_lane_pattern
    import sim_frame_gen_pkg::*;
#(
    parameter int unsigned LANE      = 0,
    parameter int unsigned NCHN      = 1,
    parameter int unsigned FRAME_LEN = 512,
    parameter int unsigned WORD_NBIT = 16,
    parameter int unsigned SW        = 9,
    parameter int unsigned FW        = 7
) (
`ifdef SIM_FRAME_PRBS_EN
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          tick,
`endif
    input  logic [SW-1:0] sample_idx,
    input  logic [FW-1:0] frame_idx,
    input  sim_mode_e     mode,
    output logic          lane_bit_c
);

    localparam logic [SW-1:0] PHASE = SW'(LANE * (FRAME_LEN / NCHN));
    localparam logic [SW-1:0] HALF  = SW'(FRAME_LEN / 2);

    logic [SW-1:0] phased_c;
    logic          square_c;
    logic [31:0]   word_c;
    logic [31:0]   bit_pos_c;
    logic          cnt_c;

    // Square: FRAME_LEN is a power of two, so the SW-bit sum wraps mod FRAME_LEN
    assign phased_c = sample_idx + PHASE;
    assign square_c = (phased_c < HALF);

    // Counter word, MSB first; only bits below WORD_NBIT are ever selected
    assign word_c    = 32'(frame_idx) + 32'(LANE);
    assign bit_pos_c = 32'(WORD_NBIT - 1) - (32'(sample_idx) % 32'(WORD_NBIT));
    assign cnt_c     = |(word_c & (32'd1 << bit_pos_c));

`ifdef SIM_FRAME_PRBS_EN
    localparam logic [6:0] SEED = 7'(1 + LANE);

    logic [6:0] lfsr_q;

    // Held at the seed while the generator is stopped, stepped on each tick
    always_ff @(posedge clk) begin
        if (reset || load) begin
            lfsr_q <= SEED;
        end else if (tick) begin
            lfsr_q <= prbs7_next(lfsr_q);
        end
    end
`endif

    always_comb begin
        lane_bit_c = square_c;
        unique case (mode)
            SIM_MODE_SQUARE: lane_bit_c = square_c;
            SIM_MODE_HIGH:   lane_bit_c = 1'b1;
            SIM_MODE_CNT:    lane_bit_c = cnt_c;
`ifdef SIM_FRAME_PRBS_EN
            SIM_MODE_PRBS:   lane_bit_c = lfsr_q[6];
`else
            SIM_MODE_PRBS:   lane_bit_c = square_c;
`endif
            default:         lane_bit_c = square_c;
        endcase
    end

endmodule

// File: rtl/sim_frame_gen.sv
// sim_frame_gen: simulated SYNC/SPCLK/DATA source in the mclk domain.
// Divides mclk by DIV = MCLK_RATE/SPCLK_RATE into a 50% sample clock, counts
// samples per frame and frames per superframe, and drives a frame sync plus
// NCHN pattern lanes.
// Ports:
//   mclk  : system clock
//   reset : synchronous, active-high reset
//   bus   : sim_frame_gen_if.master (en, mode in; spclk/sync/data, sp_tick,
//           frame_start, sample_idx, frame_idx out; all outputs registered)
// Macro SIM_FRAME_PRBS_EN enables the PRBS7 pattern for mode 3.
module sim_frame_gen
    import sim_frame_gen_pkg::*;
#(
    parameter int unsigned MCLK_RATE   = AD_MCLK_RATE,
    parameter int unsigned SPCLK_RATE  = AD_SPCLK_RATE,
    parameter int unsigned FRAME_LEN   = 512,
    parameter int unsigned SYNC_LEN    = 9,
    parameter int unsigned SUPER_LEN   = 105,
    parameter int unsigned SYNC_ACTIVE = 100,
    parameter int unsigned NCHN        = 1,
    parameter int unsigned WORD_NBIT   = 16
) (
    input  logic            mclk,
    input  logic            reset,
    sim_frame_gen_if.master bus
);

    localparam int unsigned DIV = MCLK_RATE / SPCLK_RATE;
    localparam int unsigned DW  = $clog2(DIV);
    localparam int unsigned SW  = $clog2(FRAME_LEN);
    localparam int unsigned FW  = $clog2(SUPER_LEN);

    // Elaboration-time parameter checks
    generate
        if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
            $error("sim_frame_gen: MCLK_RATE/SPCLK_RATE must be even and >= 2");
        end
        if (FRAME_LEN < 4 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_frame
            $error("sim_frame_gen: FRAME_LEN must be a power of two and >= 4");
        end
        if (SUPER_LEN < 2) begin : g_bad_super
            $error("sim_frame_gen: SUPER_LEN must be >= 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [SW-1:0]   samp_q, samp_d;
    logic [FW-1:0]   frame_q, frame_d;
    sim_mode_e       mode_q, mode_d;
    logic            spclk_q, spclk_d;
    logic            sync_q, sync_d;
    logic [NCHN-1:0] data_q, data_d;
    logic            sp_tick_q, sp_tick_d;
    logic            fstart_q, fstart_d;

    logic            tick_c;
    sim_mode_e       mode_eff_c;
    logic [NCHN-1:0] lane_bits_c;

    assign tick_c = bus.en && (div_q == DW'(DIV - 1));

    // On the en-rise cycle the freshly sampled mode already drives the lanes
    assign mode_eff_c = (state_q == ST_IDLE) ? sim_mode_e'(bus.mode) : mode_q;

    // Per-lane pattern generators
    for (genvar k = 0; k < NCHN; k++) begin : g_lane
        sim_lane_pattern #(
            .LANE      (k),
            .NCHN      (NCHN),
            .FRAME_LEN (FRAME_LEN),
            .WORD_NBIT (WORD_NBIT),
            .SW        (SW),
            .FW        (FW)
        ) u_lane (
`ifdef SIM_FRAME_PRBS_EN
            .clk        (mclk),
            .reset      (reset),
            .load       (!bus.en),
            .tick       (tick_c),
`endif
            .sample_idx (samp_q),
            .frame_idx  (frame_q),
            .mode       (mode_eff_c),
            .lane_bit_c (lane_bits_c[k])
        );
    end

    // State and output registers
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            samp_q    <= '0;
            frame_q   <= '0;
            mode_q    <= SIM_MODE_SQUARE;
            spclk_q   <= 1'b0;
            sync_q    <= 1'b0;
            data_q    <= '0;
            sp_tick_q <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            samp_q    <= samp_d;
            frame_q   <= frame_d;
            mode_q    <= mode_d;
            spclk_q   <= spclk_d;
            sync_q    <= sync_d;
            data_q    <= data_d;
            sp_tick_q <= sp_tick_d;
            fstart_q  <= fstart_d;
        end
    end

    // Next-state: counters advance while enabled; dropping en zeroes everything
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        samp_d    = samp_q;
        frame_d   = frame_q;
        mode_d    = mode_q;
        spclk_d   = 1'b0;
        sync_d    = 1'b0;
        data_d    = '0;
        sp_tick_d = 1'b0;
        fstart_d  = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            div_d   = '0;
            samp_d  = '0;
            frame_d = '0;
        end else begin
            state_d = ST_RUN;
            if (state_q == ST_IDLE) begin
                mode_d = sim_mode_e'(bus.mode);
            end

            spclk_d = (div_q < DW'(DIV / 2));
            sync_d  = (32'(samp_q) < SYNC_LEN) && (32'(frame_q) < SYNC_ACTIVE);
            data_d  = lane_bits_c;

            if (tick_c) begin
                div_d     = '0;
                sp_tick_d = 1'b1;
                if (samp_q == SW'(FRAME_LEN - 1)) begin
                    samp_d   = '0;
                    fstart_d = 1'b1;
                    mode_d   = sim_mode_e'(bus.mode);
                    frame_d  = (frame_q == FW'(SUPER_LEN - 1)) ? '0 : frame_q + FW'(1);
                end else begin
                    samp_d = samp_q + SW'(1);
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    assign bus.out_spclk   = spclk_q;
    assign bus.out_sync    = sync_q;
    assign bus.out_data    = data_q;
    assign bus.sp_tick     = sp_tick_q;
    assign bus.frame_start = fstart_q;
    assign bus.sample_idx  = samp_q;
    assign bus.frame_idx   = frame_q;

endmodule

// File: tb/tb_sim_frame_gen.sv
// Bench for sim_frame_gen with DIV=10, FRAME_LEN=16, SYNC_LEN=3, SUPER_LEN=5,
// SYNC_ACTIVE=4, NCHN=2, WORD_NBIT=4. Expected outputs come from a model
// driven by the number of enabled clock edges since en rose.
module tb_sim_frame_gen;

    localparam int unsigned DIV  = 10;
    localparam int unsigned FL   = 16;
    localparam int unsigned SL   = 3;
    localparam int unsigned SUP  = 5;
    localparam int unsigned SA   = 4;
    localparam int unsigned NCHN = 2;
    localparam int unsigned WN   = 4;
    localparam int unsigned SW   = 4;
    localparam int unsigned FW   = 3;

    logic mclk = 1'b0;
    logic reset;

    always #5 mclk = ~mclk;

    sim_frame_gen_if #(.NCHN(NCHN), .SW(SW), .FW(FW)) bus ();

    sim_frame_gen #(
        .MCLK_RATE   (1_000_000),
        .SPCLK_RATE  (100_000),
        .FRAME_LEN   (FL),
        .SYNC_LEN    (SL),
        .SUPER_LEN   (SUP),
        .SYNC_ACTIVE (SA),
        .NCHN        (NCHN),
        .WORD_NBIT   (WN)
    ) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic            spclk;
        logic            sync;
        logic [NCHN-1:0] data;
        logic            sp_tick;
        logic            frame_start;
        logic [SW-1:0]   sample;
        logic [FW-1:0]   frame;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int unsigned m_n;
    logic [1:0]  m_mode;
    logic [6:0]  m_lfsr [NCHN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (run edge %0d)", tag, obs, req, m_n);
        end
    endtask

    function automatic logic lane_exp(input int k, input int unsigned sp, input int unsigned fp);
        int unsigned word;
        logic sq;
        sq   = ((sp + k * (FL / NCHN)) % FL) < (FL / 2);
        word = (fp + k) % (1 << WN);
        case (m_mode)
            2'd1:    return 1'b1;
            2'd2:    return 1'((word >> (WN - 1 - (sp % WN))) & 1);
`ifdef SIM_FRAME_PRBS_EN
            2'd3:    return m_lfsr[k][6];
`endif
            default: return sq;
        endcase
    endfunction

    // Expected outputs after the next clock edge for inputs (r, e, m)
    task automatic model_edge(input logic r, input logic e, input logic [1:0] m, output exp_t x);
        int unsigned tp, sp, fp, t;
        x = '0;
        if (r || !e) begin
            m_n = 0;
            if (r) m_mode = 2'd0;
            for (int k = 0; k < NCHN; k++) m_lfsr[k] = 7'(1 + k);
        end else begin
            m_n++;
            if (m_n == 1) m_mode = m;
            tp = (m_n - 1) / DIV;
            sp = tp % FL;
            fp = (tp / FL) % SUP;
            t  = m_n / DIV;
            x.spclk       = ((m_n - 1) % DIV) < (DIV / 2);
            x.sync        = (sp < SL) && (fp < SA);
            for (int k = 0; k < NCHN; k++) x.data[k] = lane_exp(k, sp, fp);
            x.sp_tick     = (m_n % DIV) == 0;
            x.frame_start = (m_n % (DIV * FL)) == 0;
            x.sample      = SW'(t % FL);
            x.frame       = FW'((t / FL) % SUP);
            if (x.sp_tick) begin
                for (int k = 0; k < NCHN; k++)
                    m_lfsr[k] = {m_lfsr[k][5:0], m_lfsr[k][6] ^ m_lfsr[k][5]};
            end
            if (x.frame_start) m_mode = m;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m);
        exp_t x;
        @(negedge mclk);
        reset    = r;
        bus.en   = e;
        bus.mode = m;
        model_edge(r, e, m, x);
        sb_q.push_back(x);
        @(posedge mclk);
        #1;
        x = sb_q.pop_front();
        chk("out_spclk",   32'(bus.out_spclk),   32'(x.spclk));
        chk("out_sync",    32'(bus.out_sync),    32'(x.sync));
        chk("out_data",    32'(bus.out_data),    32'(x.data));
        chk("sp_tick",     32'(bus.sp_tick),     32'(x.sp_tick));
        chk("frame_start", 32'(bus.frame_start), 32'(x.frame_start));
        chk("sample_idx",  32'(bus.sample_idx),  32'(x.sample));
        chk("frame_idx",   32'(bus.frame_idx),   32'(x.frame));
    endtask

    task automatic run(input int cycles, input logic e, input logic [1:0] m);
        for (int i = 0; i < cycles; i++) step(1'b0, e, m);
    endtask

    initial begin
        reset    = 1'b1;
        bus.en   = 1'b0;
        bus.mode = 2'd0;
        m_n      = 0;
        m_mode   = 2'd0;
        for (int k = 0; k < NCHN; k++) m_lfsr[k] = 7'(1 + k);

        // Reset state, and reset overriding en
        repeat (3) step(1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd0);

        // Square pattern over five frames, through the superframe wrap
        run(5 * DIV * FL + 25, 1'b1, 2'd0);

        // Serial counter from a fresh start, through frame 3
        run(2, 1'b0, 2'd2);
        run(4 * DIV * FL + 10, 1'b1, 2'd2);

        // Mode 0 -> 1 at sample 5 takes effect at the next frame
        run(1, 1'b0, 2'd0);
        run(55, 1'b1, 2'd0);
        run(150, 1'b1, 2'd1);

        // Drop en at sample 9, div 4, then restart
        run(1, 1'b0, 2'd0);
        run(94, 1'b1, 2'd0);
        run(3, 1'b0, 2'd0);
        run(30, 1'b1, 2'd0);

        // Mid-frame reset with en held high
        run(47, 1'b1, 2'd2);
        step(1'b1, 1'b1, 2'd2);
        step(1'b1, 1'b1, 2'd2);

        // Mode 3 for more than one full PRBS7 period of ticks
        run(127 * DIV + 40, 1'b1, 2'd3);
        run(2, 1'b0, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
